pulse_stretch_gen: RTL and testbench

//  Transmit side of the rising-edge detect path. Converts single-cycle event

---
 rtl/pulse_stretch_gen.sv | 114 +++++++++++
 tb/tb_pulse_stretch_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretch_gen.sv
// Stretches single-cycle events into HIGH_CYCLES-high / LOW_CYCLES-low pulses.
// Events that arrive during a pulse queue in a saturating counter; drops raise a sticky overflow flag.
module pulse_stretch_gen #(
    parameter int unsigned HIGH_CYCLES = 4,
    parameter int unsigned LOW_CYCLES  = 2,
    parameter int unsigned MAX_PENDING = 7,
    localparam int unsigned PEND_W     = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pulse_in,
    input  logic              clr_overflow,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned CNT_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic cnt_done;
    logic low_exit;
    logic deq;
    logic enq;
    logic drop;

    // Queue bookkeeping for this cycle: an event is queued unless it starts a pulse directly.
    assign cnt_done = (cnt == '0);
    assign low_exit = (state == LOW) && cnt_done;
    assign deq      = low_exit && (pending != '0);
    assign enq      = pulse_in &&
                      ((state == HIGH) || ((state == LOW) && !(low_exit && (pending == '0))));
    assign drop     = enq && !deq && (pending == PEND_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            out      <= 1'b0;
            busy     <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pulse_in) begin
                        state <= HIGH;
                        cnt   <= HIGH_LOAD;
                        out   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt_done) begin
                        state <= LOW;
                        cnt   <= LOW_LOAD;
                        out   <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                LOW: begin
                    if (cnt_done) begin
                        // A queued event takes precedence; otherwise a fresh request starts immediately.
                        if ((pending != '0) || pulse_in) begin
                            state <= HIGH;
                            cnt   <= HIGH_LOAD;
                            out   <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    out   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase

            if (enq && !deq && !drop) begin
                pending <= pending + PEND_W'(1);
            end else if (deq && !enq) begin
                pending <= pending - PEND_W'(1);
            end

            // A drop in the same cycle wins over a clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_stretch_gen.sv
// Directed scoreboard bench for pulse_stretch_gen: default instance plus a HIGH=1/LOW=1 instance.
module tb_pulse_stretch_gen;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b0;
    logic       pulse_in     = 1'b0;
    logic       clr_overflow = 1'b0;

    logic       out_a, busy_a, ovf_a;
    logic [2:0] pend_a;
    logic       out_b, busy_b, ovf_b;
    logic [2:0] pend_b;

    always #5 clk = ~clk;

    pulse_stretch_gen dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .pulse_in     (pulse_in),
        .clr_overflow (clr_overflow),
        .out          (out_a),
        .busy         (busy_a),
        .pending      (pend_a),
        .overflow     (ovf_a)
    );

    pulse_stretch_gen #(
        .HIGH_CYCLES (1),
        .LOW_CYCLES  (1),
        .MAX_PENDING (7)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .pulse_in     (pulse_in),
        .clr_overflow (clr_overflow),
        .out          (out_b),
        .busy         (busy_b),
        .pending      (pend_b),
        .overflow     (ovf_b)
    );

    typedef struct {
        logic       sel;
        int         tid;
        int         row;
        logic [5:0] want;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cur_tid = 0;
    int   row_n   = 0;
    logic cur_sel = 1'b0;

    // Downstream 2-flop synchronizer plus rising-edge detector on the default instance.
    logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    int   rise_cnt = 0;
    always @(posedge clk) begin
        s1 <= out_a;
        s2 <= s1;
        s3 <= s2;
        if (s2 && !s3) rise_cnt <= rise_cnt + 1;
    end

    task automatic step(input logic r, input logic p, input logic c,
                        input logic eo, input logic eb, input logic [2:0] ep, input logic ef);
        exp_t e;
        rst_n        = r;
        pulse_in     = p;
        clr_overflow = c;
        e.sel  = cur_sel;
        e.tid  = cur_tid;
        e.row  = row_n;
        e.want = {eo, eb, ep, ef};
        exp_q.push_back(e);
        row_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic rep(input int n, input logic r, input logic p, input logic c,
                       input logic eo, input logic eb, input logic [2:0] ep, input logic ef);
        for (int i = 0; i < n; i++) step(r, p, c, eo, eb, ep, ef);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic new_test(input int tid, input logic sel);
        cur_tid = tid;
        cur_sel = sel;
        row_n   = 0;
    endtask

    // Monitor: every cycle with a queued expectation compares {out,busy,pending,overflow}.
    initial begin
        exp_t       e;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = e.sel ? {out_b, busy_b, pend_b, ovf_b} : {out_a, busy_a, pend_a, ovf_a};
                checks++;
                if (act !== e.want) begin
                    errors++;
                    $display("FAIL t%0d.r%0d dut%0d: got out=%b busy=%b pending=%0d overflow=%b, want out=%b busy=%b pending=%0d overflow=%b",
                             e.tid, e.row, e.sel, act[5], act[4], act[3:1], act[0],
                             e.want[5], e.want[4], e.want[3:1], e.want[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int n0;

        // Reset held with pulse_in high, then first edge after release starts a pulse.
        new_test(1, 1'b0);
        rep(2, 0,1,0, 0,0,3'd0,0);
        step(1,1,0, 1,1,3'd0,0);
        rep(3, 1,0,0, 1,1,3'd0,0);
        rep(2, 1,0,0, 0,1,3'd0,0);
        step(1,0,0, 0,0,3'd0,0);

        // Single event: 4 high, 2 low, then idle; one edge seen downstream.
        new_test(2, 1'b0);
        n0 = rise_cnt;
        step(1,1,0, 1,1,3'd0,0);
        rep(3, 1,0,0, 1,1,3'd0,0);
        rep(2, 1,0,0, 0,1,3'd0,0);
        step(1,0,0, 0,0,3'd0,0);
        chk("edges_single", rise_cnt - n0, 1);

        // Three consecutive events queue and replay back to back.
        new_test(3, 1'b0);
        n0 = rise_cnt;
        step(1,1,0, 1,1,3'd0,0);
        step(1,1,0, 1,1,3'd1,0);
        step(1,1,0, 1,1,3'd2,0);
        step(1,0,0, 1,1,3'd2,0);
        rep(2, 1,0,0, 0,1,3'd2,0);
        rep(4, 1,0,0, 1,1,3'd1,0);
        rep(2, 1,0,0, 0,1,3'd1,0);
        rep(4, 1,0,0, 1,1,3'd0,0);
        rep(2, 1,0,0, 0,1,3'd0,0);
        step(1,0,0, 0,0,3'd0,0);
        chk("edges_queue", rise_cnt - n0, 3);

        // Held request saturates the queue, then clear / set-wins / dequeue-no-drop cases.
        new_test(4, 1'b0);
        step(1,1,0, 1,1,3'd0,0);
        step(1,1,0, 1,1,3'd1,0);
        step(1,1,0, 1,1,3'd2,0);
        step(1,1,0, 1,1,3'd3,0);
        step(1,1,0, 0,1,3'd4,0);
        step(1,1,0, 0,1,3'd5,0);
        step(1,1,0, 1,1,3'd5,0);
        step(1,1,0, 1,1,3'd6,0);
        step(1,1,0, 1,1,3'd7,0);
        step(1,1,0, 1,1,3'd7,1);
        step(1,1,0, 0,1,3'd7,1);
        step(1,1,0, 0,1,3'd7,1);
        step(1,0,1, 1,1,3'd6,0);
        step(1,1,0, 1,1,3'd7,0);
        step(1,1,1, 1,1,3'd7,1);
        step(1,0,1, 1,1,3'd7,0);
        step(1,0,0, 0,1,3'd7,0);
        step(1,0,0, 0,1,3'd7,0);
        step(1,1,0, 1,1,3'd7,0);
        step(0,0,0, 0,0,3'd0,0);

        // LOW-exit collision keeps pending; a later empty-queue exit consumes pulse_in directly.
        new_test(5, 1'b0);
        step(1,1,0, 1,1,3'd0,0);
        step(1,1,0, 1,1,3'd1,0);
        rep(2, 1,0,0, 1,1,3'd1,0);
        rep(2, 1,0,0, 0,1,3'd1,0);
        step(1,1,0, 1,1,3'd1,0);
        rep(3, 1,0,0, 1,1,3'd1,0);
        rep(2, 1,0,0, 0,1,3'd1,0);
        rep(4, 1,0,0, 1,1,3'd0,0);
        rep(2, 1,0,0, 0,1,3'd0,0);
        step(1,1,0, 1,1,3'd0,0);
        rep(3, 1,0,0, 1,1,3'd0,0);
        rep(2, 1,0,0, 0,1,3'd0,0);
        step(1,0,0, 0,0,3'd0,0);

        // Mid-pulse reset with pending=3.
        new_test(6, 1'b0);
        step(1,1,0, 1,1,3'd0,0);
        step(1,1,0, 1,1,3'd1,0);
        step(1,1,0, 1,1,3'd2,0);
        step(1,1,0, 1,1,3'd3,0);
        rep(2, 1,0,0, 0,1,3'd3,0);
        step(1,1,0, 1,1,3'd3,0);
        step(1,0,0, 1,1,3'd3,0);
        step(0,1,0, 0,0,3'd0,0);
        step(1,0,0, 0,0,3'd0,0);

        // Same with HIGH_CYCLES=1, LOW_CYCLES=1, then a lone event.
        new_test(7, 1'b1);
        step(1,1,0, 1,1,3'd0,0);
        step(1,1,0, 0,1,3'd1,0);
        step(1,1,0, 1,1,3'd1,0);
        step(1,1,0, 0,1,3'd2,0);
        step(1,1,0, 1,1,3'd2,0);
        step(1,1,0, 0,1,3'd3,0);
        step(1,1,0, 1,1,3'd3,0);
        step(0,1,0, 0,0,3'd0,0);
        step(1,0,0, 0,0,3'd0,0);
        step(1,1,0, 1,1,3'd0,0);
        step(1,0,0, 0,1,3'd0,0);
        step(1,0,0, 0,0,3'd0,0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
